// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation/action sequencer: frame-strobed FSM that selects the
// sprite ROM index and flags the damage-dealing window of punches and kicks.
module fighter_anim_ctrl #(
   parameter int unsigned PUNCH_FRAMES = 6,
   parameter int unsigned KICK_FRAMES  = 8,
   parameter int unsigned HIT_FRAMES   = 10,
   parameter int unsigned ACTIVE_START = 2,
   parameter int unsigned ACTIVE_LEN   = 2,
   parameter int unsigned WALK_TOGGLE  = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       punch_req,
   input  logic       kick_req,
   input  logic       got_hit,
   input  logic [7:0] health,
   output logic [2:0] sprite,
   output logic       attack_active,
   output logic       attack_start,
   output logic       busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned SPR_W = 3;

   localparam logic [CNT_W-1:0] PUNCH_LAST = CNT_W'(PUNCH_FRAMES - 1);
   localparam logic [CNT_W-1:0] KICK_LAST  = CNT_W'(KICK_FRAMES - 1);
   localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TOGGLE - 1);
   localparam logic [CNT_W-1:0] ACT_FIRST  = CNT_W'(ACTIVE_START);
   localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACTIVE_START + ACTIVE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WALK  = 3'd1,
      S_PUNCH = 3'd2,
      S_KICK  = 3'd3,
      S_HIT   = 3'd4,
      S_KO    = 3'd5
   } state_e;

   state_e             state_q, state_d, req_state;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               phase_q, phase_d;
   logic               frame_q;
   logic               tick;
   logic               ko;
   logic [SPR_W-1:0]   sprite_q, sprite_d;
   logic               active_q, active_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;

   assign tick = frame_clk & ~frame_q;
   assign ko   = (health == 8'd0);

   // State, counter and registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         frame_q  <= 1'b0;
         sprite_q <= '0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         frame_q  <= frame_clk;
         sprite_q <= sprite_d;
         active_q <= active_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
      end
   end

   // Next state, frame counter and walk phase; everything holds between ticks
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      req_state = S_IDLE;
      if (ko)                          req_state = S_KO;
      else if (got_hit)                req_state = S_HIT;
      else if (punch_req)              req_state = S_PUNCH;
      else if (kick_req)               req_state = S_KICK;
      else if (move_left ^ move_right) req_state = S_WALK;
      if (tick) begin
         case (state_q)
            S_IDLE, S_WALK: state_d = req_state;
            S_PUNCH: begin
               if (ko)                        state_d = S_KO;
               else if (got_hit)              state_d = S_HIT;
               else if (cnt_q == PUNCH_LAST)  state_d = S_IDLE;
            end
            S_KICK: begin
               if (ko)                        state_d = S_KO;
               else if (got_hit)              state_d = S_HIT;
               else if (cnt_q == KICK_LAST)   state_d = S_IDLE;
            end
            S_HIT: begin
               if (ko)                        state_d = S_KO;
               else if (cnt_q == HIT_LAST)    state_d = S_IDLE;
            end
            S_KO:    state_d = S_KO;
            default: state_d = S_IDLE;
         endcase
         if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (state_q == S_WALK && cnt_q == WALK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Output decode from the upcoming state so outputs land with the state change
   always_comb begin
      sprite_d = '0;
      active_d = 1'b0;
      busy_d   = 1'b0;
      case (state_d)
         S_WALK:  sprite_d = phase_d ? SPR_W'(2) : SPR_W'(1);
         S_PUNCH: begin sprite_d = SPR_W'(3); busy_d = 1'b1; end
         S_KICK:  begin sprite_d = SPR_W'(4); busy_d = 1'b1; end
         S_HIT:   begin sprite_d = SPR_W'(5); busy_d = 1'b1; end
         S_KO:    begin sprite_d = SPR_W'(6); busy_d = 1'b1; end
         default: sprite_d = '0;
      endcase
      if ((state_d == S_PUNCH || state_d == S_KICK) &&
          cnt_d >= ACT_FIRST && cnt_d <= ACT_LAST)
         active_d = 1'b1;
      start_d = active_d & ~active_q;
   end

   assign sprite        = sprite_q;
   assign attack_active = active_q;
   assign attack_start  = start_q;
   assign busy          = busy_q;

endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
- Per-fighter animation/action sequencer; one instance per fighter (Ryu, Akuma).
- Drives the `sprite` select index of the fighter's sprite ROM block. It replaces the current hard-wired sprite constants in the colour-mapper path.
- Advances once per video frame, using the frame_clk strobe from the VGA controller. Takes move/attack requests from the keyboard logic and hit reports from the collision/health logic.
- Emits the attack-active window that health logic uses to apply damage.

Parameters:
- PUNCH_FRAMES, 6, frames a punch lasts (2..15).
- KICK_FRAMES, 8, frames a kick lasts (2..15).
- HIT_FRAMES, 10, frames of hit-stun (1..15).
- ACTIVE_START, 2, first frame index (0-based) of the attack-active window.
- ACTIVE_LEN, 2, width of the attack-active window in frames. Requirement: ACTIVE_START+ACTIVE_LEN <= PUNCH_FRAMES and <= KICK_FRAMES.
- WALK_TOGGLE, 4, frames per walk-cycle sprite swap (1..15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-high.
- frame_clk  in  1  frame strobe level from the VGA controller, synchronous to Clk.
- move_left  in  1  level, left held.
- move_right  in  1  level, right held.
- punch_req  in  1  level, punch requested.
- kick_req  in  1  level, kick requested.
- got_hit  in  1  level, opponent attack connected.
- health  in  8  current fighter health.
- sprite  out  3  sprite ROM index: 0 idle, 1 walk_a, 2 walk_b, 3 punch, 4 kick, 5 hit, 6 KO, 7 unused.
- attack_active  out  1  high during the active window of a punch or kick.
- attack_start  out  1  one-Clk pulse on the first cycle attack_active rises.
- busy  out  1  high in PUNCH, KICK, HIT, KO.

Behaviour:
- Tick generation
  - frame_d is a register of frame_clk.
  - tick = frame_clk & ~frame_d, a one-Clk pulse on the rising edge of frame_clk.
  - All inputs are sampled only on tick cycles. Between ticks, state, counter and outputs hold.
- Reset
  - state = IDLE, cnt = 0, frame_d = 0, sprite = 0, attack_active = 0, attack_start = 0, busy = 0.
  - Reset wins over tick in the same cycle.
  - Reset mid-attack or in KO returns to IDLE immediately on the next edge.
- Counter
  - cnt is 4 bits. It clears to 0 on every state change.
  - Otherwise it increments by 1 on each tick and saturates at 15.
- Request decode (priority, evaluated on tick)
  - KO (health == 0) > HIT (got_hit) > PUNCH (punch_req) > KICK (kick_req) > WALK (move_left XOR move_right) > IDLE.
  - move_left and move_right both high counts as no move.
- States (transitions occur only on tick)
  - IDLE: take the highest-priority request; if none, stay.
  - WALK: same decode as IDLE; no request returns to IDLE.
    - walk phase bit toggles whenever cnt reaches WALK_TOGGLE-1; cnt then clears.
    - sprite = 1 when phase = 0, 2 when phase = 1. Phase clears on entry to WALK.
  - PUNCH / KICK:
    - health == 0 goes to KO; got_hit goes to HIT (interrupts the attack).
    - new punch/kick/move requests are ignored.
    - at cnt == PUNCH_FRAMES-1 (resp. KICK_FRAMES-1), go to IDLE on that tick.
  - HIT:
    - health == 0 goes to KO; further got_hit is ignored (stun does not restart).
    - at cnt == HIT_FRAMES-1, go to IDLE.
  - KO: absorbing state; leaves only via Reset.
- Outputs
  - All outputs are registered and reflect the new state one Clk after the tick.
  - sprite is fixed per state: IDLE 0, WALK 1/2, PUNCH 3, KICK 4, HIT 5, KO 6.
  - attack_active = (state is PUNCH or KICK) && ACTIVE_START <= cnt <= ACTIVE_START+ACTIVE_LEN-1.
  - attack_active is forced to 0 the cycle after leaving PUNCH/KICK.
  - attack_start = attack_active & ~attack_active_prev, exactly one Clk wide per attack.
  - busy = state is PUNCH, KICK, HIT or KO.
- Simultaneous events
  - got_hit and punch_req on the same tick from IDLE: HIT.
  - health == 0 and got_hit on the same tick: KO.
  - frame_clk held high across many Clk cycles yields exactly one tick.

Test Plan:
- Reset, then 3 ticks with no inputs -> sprite = 0, busy = 0, attack_active = 0 throughout.
- punch_req pulsed for one tick from IDLE -> sprite = 3 for 6 ticks, then 0.
  - attack_active high during ticks with cnt = 2,3 only.
  - attack_start is a single pulse in the cycle after the cnt = 2 tick.
- move_right held for 10 ticks -> sprite sequence 1,1,1,1,2,2,2,2,1,1.
  - move_left and move_right both held -> sprite = 0.
- kick_req, then got_hit at kick cnt = 3 -> sprite = 5 next cycle, attack_active = 0.
  - got_hit re-asserted at HIT cnt = 5 does not extend stun; IDLE after 10 HIT ticks total.
- health = 0 with got_hit and punch_req on the same tick -> sprite = 6, busy = 1.
  - Stays for 20 ticks regardless of inputs; Reset -> sprite = 0 next cycle.
- frame_clk held high for 50 Clk during PUNCH -> cnt advances by exactly 1.
  - Reset asserted in the same cycle as a tick -> IDLE, cnt = 0.
